// File: rtl/bw_memreq_responder_if.sv
// Wishbone-classic 128-bit bus seen from the memory-request responder.
// The master modport is the responder; the slave modport is the memory/bus side.
interface bw_memreq_responder_if #(
    parameter int ABITS = 32
);
    logic             cyc_o;
    logic             stb_o;
    logic             we_o;
    logic [15:0]      sel_o;
    logic [ABITS-1:0] adr_o;
    logic [127:0]     dat_o;
    logic             ack_i;
    logic [127:0]     dat_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  ack_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output ack_i, dat_i
    );
endinterface

// File: rtl/bw_memreq_responder.sv
// Controller end of the core's memory request/response queues: tagged loads and
// stores become 128-bit Wishbone beats (split at 16-byte lines), one response each.
module bw_memreq_responder #(
    parameter int ABITS = 32,
    parameter int TMO   = 255,
    parameter int QD    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_wr,
    input  logic [7:0]       req_tid,
    input  logic [1:0]       req_func,
    input  logic [1:0]       req_sz,
    input  logic [ABITS-1:0] req_adr,
    input  logic [63:0]      req_dat,
    output logic             req_full,
    input  logic             resp_rd,
    output logic             resp_empty,
    output logic             resp_v,
    output logic [7:0]       resp_tid,
    output logic [63:0]      resp_dat,
    output logic             resp_err,
    bw_memreq_responder_if.master wb
);
    localparam int PW = $clog2(QD);
    localparam int TW = $clog2(TMO + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS1 = 2'd1;
    localparam logic [1:0] S_BUS2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] F_LOAD  = 2'd0;
    localparam logic [1:0] F_STORE = 2'd2;

    typedef struct packed {
        logic [7:0]       tid;
        logic [1:0]       func;
        logic [1:0]       sz;
        logic [ABITS-1:0] adr;
        logic [63:0]      dat;
    } req_t;

    typedef struct packed {
        logic [7:0]  tid;
        logic [63:0] dat;
        logic        err;
    } rsp_t;

    // Byte-lane selects for one 16-byte beat; hi picks the spill into the next line.
    function automatic logic [15:0] lane_mask(input logic [1:0] sz, input logic [3:0] off,
                                              input logic hi);
        logic [31:0] m;
        case (sz)
            2'd0:    m = 32'h0000_0001;
            2'd1:    m = 32'h0000_0003;
            2'd2:    m = 32'h0000_000F;
            default: m = 32'h0000_00FF;
        endcase
        m = m << off;
        return hi ? m[31:16] : m[15:0];
    endfunction

    function automatic logic [127:0] lane_wdat(input logic [63:0] d, input logic [3:0] off,
                                               input logic hi);
        logic [255:0] w;
        w = {192'b0, d} << {off, 3'b000};
        return hi ? w[255:128] : w[127:0];
    endfunction

    function automatic logic [63:0] load_ext(input logic [255:0] r, input logic [3:0] off,
                                             input logic [1:0] sz, input logic sgn);
        logic [63:0] s;
        s = 64'(r >> {off, 3'b000});
        case (sz)
            2'd0:    return {{56{sgn & s[7]}},  s[7:0]};
            2'd1:    return {{48{sgn & s[15]}}, s[15:0]};
            2'd2:    return {{32{sgn & s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    // ---------------- request queue ----------------
    req_t          rq_mem_q [QD];
    req_t          rq_mem_d [QD];
    logic [PW-1:0] rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
    logic [PW:0]   rq_cnt_q, rq_cnt_d;
    logic          rq_push, rq_pop, rq_empty;
    req_t          rq_in, rq_head;

    assign req_full = (rq_cnt_q == (PW+1)'(QD));
    assign rq_empty = (rq_cnt_q == '0);
    assign rq_push  = req_wr && !req_full;
    assign rq_head  = rq_mem_q[rq_rp_q];
    assign rq_in    = '{tid: req_tid, func: req_func, sz: req_sz, adr: req_adr, dat: req_dat};

    always_comb begin
        rq_mem_d = rq_mem_q;
        rq_wp_d  = rq_wp_q;
        rq_rp_d  = rq_rp_q;
        if (rq_push) begin
            rq_mem_d[rq_wp_q] = rq_in;
            rq_wp_d           = rq_wp_q + 1'b1;
        end
        if (rq_pop) rq_rp_d = rq_rp_q + 1'b1;
        rq_cnt_d = rq_cnt_q + (PW+1)'(rq_push) - (PW+1)'(rq_pop);
    end

    // ---------------- response queue ----------------
    rsp_t          rs_mem_q [QD];
    rsp_t          rs_mem_d [QD];
    logic [PW-1:0] rs_wp_q, rs_wp_d, rs_rp_q, rs_rp_d;
    logic [PW:0]   rs_cnt_q, rs_cnt_d;
    logic          rs_push, rs_pop, rs_full;
    rsp_t          rs_in, rs_head;
    logic          resp_v_q, resp_v_d, resp_err_q, resp_err_d;
    logic [7:0]    resp_tid_q, resp_tid_d;
    logic [63:0]   resp_dat_q, resp_dat_d;

    assign rs_full    = (rs_cnt_q == (PW+1)'(QD));
    assign resp_empty = (rs_cnt_q == '0);
    assign rs_pop     = resp_rd && !resp_empty;
    assign rs_head    = rs_mem_q[rs_rp_q];

    always_comb begin
        rs_mem_d   = rs_mem_q;
        rs_wp_d    = rs_wp_q;
        rs_rp_d    = rs_rp_q;
        resp_v_d   = rs_pop;
        resp_tid_d = resp_tid_q;
        resp_dat_d = resp_dat_q;
        resp_err_d = resp_err_q;
        if (rs_push) begin
            rs_mem_d[rs_wp_q] = rs_in;
            rs_wp_d           = rs_wp_q + 1'b1;
        end
        if (rs_pop) begin
            rs_rp_d    = rs_rp_q + 1'b1;
            resp_tid_d = rs_head.tid;
            resp_dat_d = rs_head.dat;
            resp_err_d = rs_head.err;
        end
        rs_cnt_d = rs_cnt_q + (PW+1)'(rs_push) - (PW+1)'(rs_pop);
    end

    assign resp_v   = resp_v_q;
    assign resp_tid = resp_tid_q;
    assign resp_dat = resp_dat_q;
    assign resp_err = resp_err_q;

    // ---------------- bus FSM ----------------
    logic [1:0]       state_q, state_d;
    req_t             cur_q, cur_d;
    logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, err_q, err_d;
    logic [15:0]      sel_q, sel_d;
    logic [ABITS-1:0] adr_q, adr_d;
    logic [127:0]     wdat_q, wdat_d, rlo_q, rlo_d, rhi_q, rhi_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0]       gap_q, gap_d;
    logic             tmo_hit, cur_split;

    assign tmo_hit   = (tmo_q == TW'(TMO - 1));
    assign cur_split = |lane_mask(cur_q.sz, cur_q.adr[3:0], 1'b1);

    always_comb begin
        rs_in.tid = cur_q.tid;
        rs_in.err = err_q;
        rs_in.dat = (err_q || cur_q.func == F_STORE) ? 64'd0 :
                    load_ext({rhi_q, rlo_q}, cur_q.adr[3:0], cur_q.sz, cur_q.func == F_LOAD);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        rlo_d   = rlo_q;
        rhi_d   = rhi_q;
        err_d   = err_q;
        rq_pop  = 1'b0;
        rs_push = 1'b0;
        case (state_q)
            S_IDLE: if (!rq_empty) begin
                rq_pop  = 1'b1;
                cur_d   = rq_head;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = (rq_head.func == F_STORE);
                sel_d   = lane_mask(rq_head.sz, rq_head.adr[3:0], 1'b0);
                adr_d   = {rq_head.adr[ABITS-1:4], 4'h0};
                wdat_d  = lane_wdat(rq_head.dat, rq_head.adr[3:0], 1'b0);
                tmo_d   = '0;
                err_d   = 1'b0;
                rlo_d   = '0;
                rhi_d   = '0;
                state_d = S_BUS1;
            end
            S_BUS1: begin
                if (wb.ack_i) begin
                    rlo_d   = wb.dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    gap_d   = 2'd2;
                    state_d = cur_split ? S_BUS2 : S_RESP;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BUS2: begin
                // gap_q counts down the bus-idle gap; the second beat launches as it expires
                if (gap_q != 2'd0) begin
                    gap_d = gap_q - 2'd1;
                    if (gap_q == 2'd1) begin
                        cyc_d  = 1'b1;
                        stb_d  = 1'b1;
                        sel_d  = lane_mask(cur_q.sz, cur_q.adr[3:0], 1'b1);
                        adr_d  = {cur_q.adr[ABITS-1:4], 4'h0} + ABITS'(16);
                        wdat_d = lane_wdat(cur_q.dat, cur_q.adr[3:0], 1'b1);
                        tmo_d  = '0;
                    end
                end else if (wb.ack_i) begin
                    rhi_d   = wb.dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: if (!rs_full) begin
                rs_push = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign wb.cyc_o = cyc_q;
    assign wb.stb_o = stb_q;
    assign wb.we_o  = we_q;
    assign wb.sel_o = sel_q;
    assign wb.adr_o = adr_q;
    assign wb.dat_o = wdat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QD; i++) begin
                rq_mem_q[i] <= '0;
                rs_mem_q[i] <= '0;
            end
            rq_wp_q    <= '0;
            rq_rp_q    <= '0;
            rq_cnt_q   <= '0;
            rs_wp_q    <= '0;
            rs_rp_q    <= '0;
            rs_cnt_q   <= '0;
            resp_v_q   <= 1'b0;
            resp_tid_q <= '0;
            resp_dat_q <= '0;
            resp_err_q <= 1'b0;
            state_q    <= S_IDLE;
            cur_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            rlo_q      <= '0;
            rhi_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rq_mem_q   <= rq_mem_d;
            rs_mem_q   <= rs_mem_d;
            rq_wp_q    <= rq_wp_d;
            rq_rp_q    <= rq_rp_d;
            rq_cnt_q   <= rq_cnt_d;
            rs_wp_q    <= rs_wp_d;
            rs_rp_q    <= rs_rp_d;
            rs_cnt_q   <= rs_cnt_d;
            resp_v_q   <= resp_v_d;
            resp_tid_q <= resp_tid_d;
            resp_dat_q <= resp_dat_d;
            resp_err_q <= resp_err_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            rlo_q      <= rlo_d;
            rhi_q      <= rhi_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_bw_memreq_responder.sv
// Directed vector bench for bw_memreq_responder: table of single transactions
// plus hand sequences for timeout, queue back-pressure and mid-cycle reset.
module tb_bw_memreq_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_wr = 1'b0;
    logic [7:0]  req_tid = '0;
    logic [1:0]  req_func = '0;
    logic [1:0]  req_sz = '0;
    logic [31:0] req_adr = '0;
    logic [63:0] req_dat = '0;
    logic        req_full;
    logic        resp_rd = 1'b0;
    logic        resp_empty, resp_v, resp_err;
    logic [7:0]  resp_tid;
    logic [63:0] resp_dat;

    int n_vec  = 0;
    int n_miss = 0;

    bw_memreq_responder_if #(.ABITS(32)) wb_if ();

    bw_memreq_responder #(.ABITS(32), .TMO(255), .QD(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_wr(req_wr), .req_tid(req_tid), .req_func(req_func), .req_sz(req_sz),
        .req_adr(req_adr), .req_dat(req_dat), .req_full(req_full),
        .resp_rd(resp_rd), .resp_empty(resp_empty), .resp_v(resp_v),
        .resp_tid(resp_tid), .resp_dat(resp_dat), .resp_err(resp_err),
        .wb(wb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   func;
        logic [1:0]   sz;
        logic [31:0]  adr;
        logic [63:0]  wdat;
        int           wt;
        logic [127:0] rd1;
        logic [127:0] rd2;
        logic [15:0]  sel1;
        logic [15:0]  sel2;
        logic [31:0]  adr1;
        logic [31:0]  adr2;
        logic         split;
        logic [127:0] dato1;
        logic [127:0] dato2;
        logic [63:0]  rdat;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_req(input logic [7:0] tid, input logic [1:0] f, input logic [1:0] sz,
                            input logic [31:0] a, input logic [63:0] d);
        req_wr = 1'b1; req_tid = tid; req_func = f; req_sz = sz; req_adr = a; req_dat = d;
        @(negedge clk);
        req_wr = 1'b0;
    endtask

    task automatic beat(input logic [15:0] sel, input logic [31:0] a, input logic we,
                        input logic [127:0] dato, input logic chkd, input int wt,
                        input logic [127:0] rd);
        int n = 0;
        while (!wb_if.cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_cyc", 128'(wb_if.cyc_o), 128'd1);
        chk("stb_o", 128'(wb_if.stb_o), 128'd1);
        chk("sel_o", 128'(wb_if.sel_o), 128'(sel));
        chk("adr_o", 128'(wb_if.adr_o), 128'(a));
        chk("we_o", 128'(wb_if.we_o), 128'(we));
        if (chkd) chk("dat_o", wb_if.dat_o, dato);
        repeat (wt) @(negedge clk);
        wb_if.ack_i = 1'b1;
        wb_if.dat_i = rd;
        @(negedge clk);
        wb_if.ack_i = 1'b0;
        wb_if.dat_i = '0;
        chk("ack_drop", 128'(wb_if.cyc_o), 128'd0);
    endtask

    task automatic pop(input logic [7:0] tid, input logic [63:0] d, input logic e);
        resp_rd = 1'b1;
        @(negedge clk);
        resp_rd = 1'b0;
        chk("resp_v", 128'(resp_v), 128'd1);
        chk("resp_tid", 128'(resp_tid), 128'(tid));
        chk("resp_dat", 128'(resp_dat), 128'(d));
        chk("resp_err", 128'(resp_err), 128'(e));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic cyc_seen;
        int   cnt;
        wb_if.ack_i = 1'b0;
        wb_if.dat_i = '0;

        //         func  sz     adr            wdat            wt rd1                                           rd2            sel1      sel2      adr1            adr2          split dato1                                         dato2        rdat
        vt[0] = '{2'd0, 2'd3, 32'h0000_1000, 64'h0,           2, 128'h8000_0000_0000_0001,                     128'h0,        16'h00FF, 16'h0000, 32'h0000_1000, 32'h0,        1'b0, 128'h0,                                       128'h0,      64'h8000_0000_0000_0001};
        vt[1] = '{2'd0, 2'd0, 32'h0000_2003, 64'h0,           0, 128'hF000_0000,                               128'h0,        16'h0008, 16'h0000, 32'h0000_2000, 32'h0,        1'b0, 128'h0,                                       128'h0,      64'hFFFF_FFFF_FFFF_FFF0};
        vt[2] = '{2'd1, 2'd0, 32'h0000_2003, 64'h0,           0, 128'hF000_0000,                               128'h0,        16'h0008, 16'h0000, 32'h0000_2000, 32'h0,        1'b0, 128'h0,                                       128'h0,      64'h0000_0000_0000_00F0};
        vt[3] = '{2'd2, 2'd2, 32'h0000_300E, 64'hDEAD_BEEF,   1, 128'h0,                                       128'h0,        16'hC000, 16'h0003, 32'h0000_3000, 32'h0000_3010, 1'b1, 128'hBEEF_0000_0000_0000_0000_0000_0000_0000, 128'hDEAD, 64'h0};
        vt[4] = '{2'd0, 2'd1, 32'h0000_400F, 64'h0,           0, 128'h3400_0000_0000_0000_0000_0000_0000_0000, 128'h92,       16'h8000, 16'h0001, 32'h0000_4000, 32'h0000_4010, 1'b1, 128'h0,                                       128'h0,      64'hFFFF_FFFF_FFFF_9234};
        vt[5] = '{2'd3, 2'd2, 32'h0000_5004, 64'h0,           1, 128'h89AB_CDEF_0000_0000,                     128'h0,        16'h00F0, 16'h0000, 32'h0000_5000, 32'h0,        1'b0, 128'h0,                                       128'h0,      64'h0000_0000_89AB_CDEF};
        vt[6] = '{2'd0, 2'd3, 32'hFFFF_FFFC, 64'h0,           0, 128'h4433_2211_0000_0000_0000_0000_0000_0000, 128'h8877_6655, 16'hF000, 16'h000F, 32'hFFFF_FFF0, 32'h0000_0000, 1'b1, 128'h0,                                       128'h0,      64'h8877_6655_4433_2211};
        vt[7] = '{2'd2, 2'd0, 32'h0000_6007, 64'hA5,          0, 128'h0,                                       128'h0,        16'h0080, 16'h0000, 32'h0000_6000, 32'h0,        1'b0, 128'hA500_0000_0000_0000,                       128'h0,      64'h0};
        vt[8] = '{2'd0, 2'd1, 32'h0000_7000, 64'h0,           0, 128'h7FFF,                                    128'h0,        16'h0003, 16'h0000, 32'h0000_7000, 32'h0,        1'b0, 128'h0,                                       128'h0,      64'h0000_0000_0000_7FFF};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cyc", 128'(wb_if.cyc_o), 128'd0);
        chk("rst_stb", 128'(wb_if.stb_o), 128'd0);
        chk("rst_we", 128'(wb_if.we_o), 128'd0);
        chk("rst_sel", 128'(wb_if.sel_o), 128'd0);
        chk("rst_adr", 128'(wb_if.adr_o), 128'd0);
        chk("rst_dat_o", wb_if.dat_o, 128'd0);
        chk("rst_req_full", 128'(req_full), 128'd0);
        chk("rst_resp_empty", 128'(resp_empty), 128'd1);
        chk("rst_resp_v", 128'(resp_v), 128'd0);
        chk("rst_resp_tid", 128'(resp_tid), 128'd0);
        chk("rst_resp_dat", 128'(resp_dat), 128'd0);
        chk("rst_resp_err", 128'(resp_err), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table of single transactions
        for (int i = 0; i < 9; i++) begin
            logic [7:0] tid;
            logic       st;
            tid = 8'(8'h10 + i);
            st  = (vt[i].func == 2'd2);
            push_req(tid, vt[i].func, vt[i].sz, vt[i].adr, vt[i].wdat);
            chk("issue_early", 128'(wb_if.cyc_o), 128'd0);
            @(negedge clk);
            chk("issue_lat", 128'(wb_if.cyc_o), 128'd1);
            beat(vt[i].sel1, vt[i].adr1, st, vt[i].dato1, st, vt[i].wt, vt[i].rd1);
            if (vt[i].split) begin
                @(negedge clk);
                chk("split_gap", 128'(wb_if.cyc_o), 128'd0);
                @(negedge clk);
                chk("split_rise", 128'(wb_if.cyc_o), 128'd1);
                beat(vt[i].sel2, vt[i].adr2, st, vt[i].dato2, st, 0, vt[i].rd2);
            end
            chk("resp_early", 128'(resp_empty), 128'd1);
            @(negedge clk);
            chk("resp_lat", 128'(resp_empty), 128'd0);
            pop(tid, vt[i].rdat, 1'b0);
        end

        // bus timeout, then the queued request still issues
        push_req(8'h50, 2'd0, 2'd3, 32'h0000_8000, 64'h0);
        push_req(8'h51, 2'd1, 2'd0, 32'h0000_9001, 64'h0);
        chk("tmo_issue", 128'(wb_if.cyc_o), 128'd1);
        cnt = 0;
        while (wb_if.cyc_o && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", 128'(cnt), 128'd255);
        beat(16'h0002, 32'h0000_9000, 1'b0, 128'h0, 1'b0, 0, 128'h7700);
        @(negedge clk);
        pop(8'h50, 64'h0, 1'b1);
        pop(8'h51, 64'h77, 1'b0);

        // back-pressure: 6 back-to-back pushes, first issues, 4 queue, last dropped
        for (int k = 0; k < 6; k++) begin
            push_req(8'(8'h60 + k), 2'd1, 2'd3, 32'h0, 64'h0);
            if (k == 3) chk("req_full_3", 128'(req_full), 128'd0);
            if (k == 4) chk("req_full_4", 128'(req_full), 128'd1);
        end
        chk("req_full_drop", 128'(req_full), 128'd1);
        for (int k = 0; k < 5; k++)
            beat(16'h00FF, 32'h0, 1'b0, 128'h0, 1'b0, 0, 128'(8'h60 + k));
        push_req(8'h66, 2'd1, 2'd3, 32'h0, 64'h0);
        cyc_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            cyc_seen |= wb_if.cyc_o;
        end
        chk("held_in_resp", 128'(cyc_seen), 128'd0);
        for (int k = 0; k < 5; k++)
            pop(8'(8'h60 + k), 64'(8'h60 + k), 1'b0);
        beat(16'h00FF, 32'h0, 1'b0, 128'h0, 1'b0, 0, 128'h66);
        @(negedge clk);
        pop(8'h66, 64'h66, 1'b0);
        @(negedge clk);
        chk("drained_empty", 128'(resp_empty), 128'd1);
        resp_rd = 1'b1;
        @(negedge clk);
        resp_rd = 1'b0;
        chk("rd_on_empty", 128'(resp_v), 128'd0);

        // reset while a bus cycle is open and a request is queued
        push_req(8'h70, 2'd0, 2'd3, 32'h0000_A000, 64'h0);
        push_req(8'h71, 2'd0, 2'd3, 32'h0000_B000, 64'h0);
        chk("pre_rst_cyc", 128'(wb_if.cyc_o), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_cyc_drop", 128'(wb_if.cyc_o), 128'd0);
        chk("rst_q_empty", 128'(resp_empty), 128'd1);
        chk("rst_sel_clr", 128'(wb_if.sel_o), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            cyc_seen |= wb_if.cyc_o;
        end
        chk("post_rst_idle", 128'(cyc_seen), 128'd0);
        chk("post_rst_no_resp", 128'(resp_empty), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
